// File: rtl/rr_arb_hold.sv
// Round-robin arbiter with a registered one-hot grant.
// The grant is held until the downstream accepts the last beat.
`timescale 1ns/1ps
module rr_arb_hold #(
  parameter  int W     = 8,
  localparam int IDX_W = $clog2(W)
) (
  input  logic             clk,
  input  logic             arst_n,
  input  logic [W-1:0]     i_req,
  input  logic             i_ack,
  input  logic             i_last,
  output logic [W-1:0]     o_gnt,
  output logic             o_gnt_vld,
  output logic [IDX_W-1:0] o_gnt_idx
);

  typedef enum logic {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } state_t;

  state_t         state;
  state_t         state_nxt;
  logic [W-1:0]   gnt;
  logic [W-1:0]   gnt_nxt;
  logic [W-1:0]   ptr;
  logic [W-1:0]   ptr_nxt;
  logic           done;

  function automatic logic [W-1:0] lowest(
    input logic [W-1:0] x
  );
    return x & (~x + W'(1));
  endfunction

  // bits strictly above the one-hot pointer
  function automatic logic [W-1:0] above_of(
    input logic [W-1:0] p
  );
    return ~(p | (p - W'(1)));
  endfunction

  // first requester after p, wrapping to the lowest
  function automatic logic [W-1:0] pick(
    input logic [W-1:0] r,
    input logic [W-1:0] p
  );
    logic [W-1:0] above;
    above = r & above_of(p);
    return (|above) ? lowest(above) : lowest(r);
  endfunction

  assign done = i_ack & i_last;

  // state, grant and priority pointer registers
  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      state <= IDLE;
      gnt   <= '0;
      ptr   <= {1'b1, {(W-1){1'b0}}};
    end else begin
      state <= state_nxt;
      gnt   <= gnt_nxt;
      ptr   <= ptr_nxt;
    end
  end

  // next grant: issue from idle, rotate only when a transaction ends
  always_comb begin
    state_nxt = state;
    gnt_nxt   = gnt;
    ptr_nxt   = ptr;
    unique case (state)
      IDLE: begin
        if (|i_req) begin
          state_nxt = GRANT;
          gnt_nxt   = pick(i_req, ptr);
        end
      end
      GRANT: begin
        if (done) begin
          ptr_nxt   = gnt;
          gnt_nxt   = pick(i_req & ~gnt, gnt);
          state_nxt = (|gnt_nxt) ? GRANT : IDLE;
        end
      end
    endcase
  end

  // outputs decoded from the registered grant
  always_comb begin
    o_gnt     = gnt;
    o_gnt_vld = |gnt;
    o_gnt_idx = '0;
    for (int i = 0; i < W; i++) begin
      if (gnt[i]) o_gnt_idx = o_gnt_idx | IDX_W'(i);
    end
  end

endmodule

// File: tb/tb_rr_arb_hold.sv
// Directed table-driven bench for rr_arb_hold (W=8).
// Rows give inputs for one cycle and the grant expected after that edge.
`timescale 1ns/1ps
module tb_rr_arb_hold;

  logic       clk;
  logic       arst_n;
  logic [7:0] i_req;
  logic       i_ack;
  logic       i_last;
  logic [7:0] o_gnt;
  logic       o_gnt_vld;
  logic [2:0] o_gnt_idx;

  int pass_cnt;
  int total_cnt;

  typedef struct {
    logic       rst;
    logic [7:0] req;
    logic       ack;
    logic       last;
    logic [7:0] gnt;
  } vec_t;

  vec_t tv[$];

  rr_arb_hold #(.W(8)) dut (
    .clk       (clk),
    .arst_n    (arst_n),
    .i_req     (i_req),
    .i_ack     (i_ack),
    .i_last    (i_last),
    .o_gnt     (o_gnt),
    .o_gnt_vld (o_gnt_vld),
    .o_gnt_idx (o_gnt_idx)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (arst_n) begin
      assert ($onehot0(o_gnt))
        else $error("grant not onehot0: %h", o_gnt);
      assert (o_gnt_vld == (|o_gnt))
        else $error("vld inconsistent with grant");
      if (o_gnt_vld)
        assert (o_gnt[o_gnt_idx])
          else $error("idx %0d not granted", o_gnt_idx);
      if (o_gnt_vld && !(i_ack && i_last))
        assert (|(i_req & o_gnt))
          else $error("protocol: granted req dropped early");
    end
  end

  function automatic logic [2:0] idx_of(input logic [7:0] g);
    logic [2:0] r;
    r = '0;
    for (int i = 0; i < 8; i++)
      if (g[i]) r = 3'(i);
    return r;
  endfunction

  task automatic chk(input string nm,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    total_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %0h want %0h", nm, act, exp);
  endtask

  task automatic chk_all(input string nm, input logic [7:0] g);
    chk({nm, " gnt"}, 32'(o_gnt), 32'(g));
    chk({nm, " vld"}, 32'(o_gnt_vld), 32'(|g));
    chk({nm, " idx"}, 32'(o_gnt_idx), 32'(idx_of(g)));
  endtask

  task automatic add(input logic r, input logic [7:0] q,
                     input logic a, input logic l,
                     input logic [7:0] g);
    vec_t v;
    v.rst = r; v.req = q; v.ack = a; v.last = l; v.gnt = g;
    tv.push_back(v);
  endtask

  initial begin
    pass_cnt  = 0;
    total_cnt = 0;

    // hold-and-release: single requester, wait states, drop to idle
    add(1, 8'h00, 0, 0, 8'h00);
    add(0, 8'h04, 0, 0, 8'h04);
    repeat (5) add(0, 8'h04, 0, 0, 8'h04);
    add(0, 8'h00, 1, 1, 8'h00);
    add(0, 8'hFF, 0, 0, 8'h08);
    add(0, 8'hFF, 1, 1, 8'h10);
    // full rotation, back-to-back
    add(1, 8'hFF, 0, 0, 8'h00);
    add(0, 8'hFF, 0, 0, 8'h01);
    for (int k = 1; k < 8; k++)
      add(0, 8'hFF, 1, 1, 8'(1 << k));
    add(0, 8'hFF, 1, 1, 8'h01);
    // wrap from idx 6, then lone requester gap
    add(1, 8'h00, 0, 0, 8'h00);
    add(0, 8'h40, 0, 0, 8'h40);
    add(0, 8'h41, 1, 1, 8'h01);
    add(0, 8'h01, 1, 1, 8'h00);
    add(0, 8'h01, 0, 0, 8'h01);
    add(0, 8'h01, 1, 1, 8'h00);
    add(0, 8'h01, 0, 0, 8'h01);
    // idle ack ignored, multi-beat hold, last without ack
    add(1, 8'h00, 0, 0, 8'h00);
    add(0, 8'h00, 1, 1, 8'h00);
    add(0, 8'h08, 0, 0, 8'h08);
    repeat (3) add(0, 8'hFF, 1, 0, 8'h08);
    add(0, 8'hFF, 0, 1, 8'h08);
    add(0, 8'hFF, 1, 1, 8'h10);

    // reset held with all requesting
    arst_n = 1'b0;
    i_req  = 8'hFF;
    i_ack  = 1'b0;
    i_last = 1'b0;
    repeat (3) begin
      @(posedge clk); #1;
      chk_all("in_reset", 8'h00);
    end
    @(negedge clk);
    arst_n = 1'b1;
    @(posedge clk); #1;
    chk_all("first_grant", 8'h01);

    for (int i = 0; i < tv.size(); i++) begin
      arst_n = ~tv[i].rst;
      i_req  = tv[i].req;
      i_ack  = tv[i].ack;
      i_last = tv[i].last;
      @(posedge clk); #1;
      chk_all($sformatf("row%0d", i), tv[i].gnt);
    end

    // async reset in the middle of a grant
    arst_n = 1'b0;
    i_req  = 8'h20;
    i_ack  = 1'b0;
    i_last = 1'b0;
    @(posedge clk); #1;
    arst_n = 1'b1;
    @(posedge clk); #1;
    chk_all("pre_areset", 8'h20);
    #2;
    arst_n = 1'b0;
    #1;
    chk_all("areset_now", 8'h00);
    i_req = 8'hFF;
    @(negedge clk);
    arst_n = 1'b1;
    @(posedge clk); #1;
    chk_all("after_areset", 8'h01);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
